// File: rtl/fb_rect_writer.sv
// Purpose : fills a clipped axis-aligned rectangle of one colour into the row-major framebuffer.
// Latency : start taken in cycle T -> SETUP in T+1 -> first write in T+2, then one cell per accepted write.
// Backpr. : we/waddr/wdata held stable while wready is low; ready only in IDLE, start otherwise dropped.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, ready        request handshake (taken when start & ready)
//   x0, y0, w, h, color rectangle origin, size and fill colour (latched on accept)
//   abort               cancel an in-flight fill (SETUP/DRAW only), no done pulse
//   busy, done          busy in SETUP/DRAW; done is a one-cycle completion pulse
//   we, waddr, wdata    framebuffer write port, transfer when we & wready
//   wready              write accept from the framebuffer
module fb_rect_writer #(
    parameter int HSIZE  = 160,
    parameter int VSIZE  = 120,
    parameter int XWIDTH = 8,
    parameter int YWIDTH = 7,
    parameter int AWIDTH = 15,
    parameter int CWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [XWIDTH-1:0] x0,
    input  logic [YWIDTH-1:0] y0,
    input  logic [XWIDTH-1:0] w,
    input  logic [YWIDTH-1:0] h,
    input  logic [CWIDTH-1:0] color,
    input  logic              abort,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              we,
    output logic [AWIDTH-1:0] waddr,
    output logic [CWIDTH-1:0] wdata,
    input  logic              wready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [XWIDTH:0]   HLIM  = (XWIDTH+1)'(HSIZE);
    localparam logic [YWIDTH:0]   VLIM  = (YWIDTH+1)'(VSIZE);
    localparam logic [AWIDTH-1:0] HSTEP = AWIDTH'(HSIZE);

    logic [1:0]        state;
    logic [XWIDTH-1:0] lx0, lw, x;
    logic [YWIDTH-1:0] ly0, lh, y;
    logic [CWIDTH-1:0] lcolor;
    logic [XWIDTH:0]   xe;
    logic [YWIDTH:0]   ye;
    logic [AWIDTH-1:0] row_base;

    // Clip against the framebuffer using one extra bit so x0+w / y0+h never wrap.
    logic [XWIDTH:0]   xsum, xe_c;
    logic [YWIDTH:0]   ysum, ye_c;
    logic              empty;
    logic [AWIDTH-1:0] setup_base;
    logic              row_end, last_row, accept;

    always_comb begin
        xsum       = {1'b0, lx0} + {1'b0, lw};
        ysum       = {1'b0, ly0} + {1'b0, lh};
        xe_c       = (xsum > HLIM) ? HLIM : xsum;
        ye_c       = (ysum > VLIM) ? VLIM : ysum;
        empty      = (lw == '0) || (lh == '0) || ({1'b0, lx0} >= HLIM) || ({1'b0, ly0} >= VLIM);
        // The only multiply; it happens once per rectangle in SETUP, DRAW steps rows with an adder.
        setup_base = AWIDTH'(ly0) * HSTEP;
        row_end    = ({1'b0, x} == (xe - 1'b1));
        last_row   = ({1'b0, y} == (ye - 1'b1));
        accept     = we && wready;
    end

    assign ready = (state == S_IDLE);
    assign busy  = (state == S_SETUP) || (state == S_DRAW);
    assign done  = (state == S_DONE);
    assign we    = (state == S_DRAW);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            lx0      <= '0;
            ly0      <= '0;
            lw       <= '0;
            lh       <= '0;
            lcolor   <= '0;
            xe       <= '0;
            ye       <= '0;
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            waddr    <= '0;
            wdata    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // abort is meaningless here, so start always wins.
                    if (start) begin
                        lx0    <= x0;
                        ly0    <= y0;
                        lw     <= w;
                        lh     <= h;
                        lcolor <= color;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (empty) begin
                        state <= S_DONE;
                    end else begin
                        xe       <= xe_c;
                        ye       <= ye_c;
                        x        <= lx0;
                        y        <= ly0;
                        row_base <= setup_base;
                        waddr    <= setup_base + AWIDTH'(lx0);
                        wdata    <= lcolor;
                        state    <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    // A write accepted in the abort cycle has already reached the framebuffer.
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (accept) begin
                        if (row_end) begin
                            if (last_row) begin
                                state <= S_DONE;
                            end else begin
                                x        <= lx0;
                                y        <= y + 1'b1;
                                row_base <= row_base + HSTEP;
                                waddr    <= row_base + HSTEP + AWIDTH'(lx0);
                            end
                        end else begin
                            x     <= x + 1'b1;
                            waddr <= waddr + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_writer.sv
module tb_fb_rect_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        wready = 1'b1;
    logic [7:0]  x0 = '0;
    logic [7:0]  w = '0;
    logic [6:0]  y0 = '0;
    logic [6:0]  h = '0;
    logic [11:0] color = '0;
    logic        ready, busy, done, we;
    logic [14:0] waddr;
    logic [11:0] wdata;

    fb_rect_writer dut (
        .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
        .color(color), .abort(abort), .ready(ready), .busy(busy), .done(done),
        .we(we), .waddr(waddr), .wdata(wdata), .wready(wready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int wr_mode = 0;  // 0: always ready, 1: alternate, 2: random
    int exp_addr_q[$];
    int exp_data_q[$];
    int acc_cnt = 0, done_cnt = 0, done_cyc = 0, first_we_cyc = 0, last_acc_cyc = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (wr_mode)
            1:       wready = ~wready;
            2:       wready = 1'($urandom_range(0, 1));
            default: wready = 1'b1;
        endcase
    end

    // Monitor: pops the scoreboard on every accepted write.
    initial begin
        logic        prev_stall;
        logic        prev_we;
        logic [14:0] held_addr;
        logic [11:0] held_data;
        prev_stall = 1'b0;
        prev_we    = 1'b0;
        held_addr  = '0;
        held_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                prev_we    = 1'b0;
            end else begin
                if (we && prev_stall) begin
                    chk("stall_addr_hold", int'(waddr), int'(held_addr));
                    chk("stall_data_hold", int'(wdata), int'(held_data));
                end
                if (we && !prev_we) first_we_cyc = cyc;
                if (we && wready) begin
                    if (exp_addr_q.size() == 0) begin
                        chk("unexpected_write_addr", int'(waddr), -1);
                    end else begin
                        chk("write_addr", int'(waddr), exp_addr_q.pop_front());
                        chk("write_data", int'(wdata), exp_data_q.pop_front());
                    end
                    acc_cnt++;
                    last_acc_cyc = cyc;
                end
                prev_stall = we && !wready;
                prev_we    = we;
                held_addr  = waddr;
                held_data  = wdata;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    // Reference: every cell inside the rectangle intersected with the 160x120 frame, row-major.
    function automatic int push_model(input int px, input int py, input int pw, input int ph, input int pc);
        int n = 0;
        for (int yy = py; yy < py + ph && yy < 120; yy++) begin
            for (int xx = px; xx < px + pw && xx < 160; xx++) begin
                exp_addr_q.push_back(yy * 160 + xx);
                exp_data_q.push_back(pc);
                n++;
            end
        end
        return n;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 100 && !ready; i++) tick();
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic issue(input int px, input int py, input int pw, input int ph, input int pc);
        x0    = 8'(px);
        y0    = 7'(py);
        w     = 8'(pw);
        h     = 7'(ph);
        color = 12'(pc);
        start = 1'b1;
    endtask

    task automatic run_rect(input int px, input int py, input int pw, input int ph, input int pc);
        int n, a0, d0, c0;
        wait_ready();
        n  = push_model(px, py, pw, ph, pc);
        a0 = acc_cnt;
        d0 = done_cnt;
        issue(px, py, pw, ph, pc);
        c0 = cyc;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30000 && !done; i++) tick();
        if (!done) chk("done_timeout", 0, 1);
        tick();
        chk("ready_after_done", int'(ready), 1);
        chk("done_one_cycle", int'(done), 0);
        chk("done_count", done_cnt - d0, 1);
        chk("write_count", acc_cnt - a0, n);
        chk("queue_drained", exp_addr_q.size(), 0);
        if (n == 0) begin
            chk("empty_done_latency", done_cyc - c0, 2);
        end else begin
            chk("first_we_latency", first_we_cyc - c0, 2);
            chk("done_after_last_write", done_cyc - last_acc_cyc, 1);
        end
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    initial begin
        int a0, d0, n;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_ready", int'(ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_we", int'(we), 0);
        chk("reset_waddr", int'(waddr), 0);
        chk("reset_wdata", int'(wdata), 0);
        rst = 1'b0;
        tick();

        // Directed cases.
        run_rect(2, 3, 3, 2, 'hF00);
        run_rect(158, 118, 10, 10, 'h0A5);
        run_rect(10, 10, 0, 5, 'h123);
        run_rect(200, 10, 5, 5, 'h456);
        wr_mode = 1;
        run_rect(2, 3, 3, 2, 'hF00);
        wr_mode = 0;

        // Abort a full-frame fill after 50 writes; a spurious start while busy must be dropped.
        wait_ready();
        n  = push_model(0, 0, 160, 120, 'h7E7);
        a0 = acc_cnt;
        d0 = done_cnt;
        issue(0, 0, 160, 120, 'h7E7);
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && acc_cnt - a0 < 20; i++) tick();
        issue(100, 50, 5, 5, 'h111);
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && acc_cnt - a0 < 50; i++) tick();
        chk("abort_precount", acc_cnt - a0, 50);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_we", int'(we), 0);
        chk("abort_ready", int'(ready), 1);
        chk("abort_busy", int'(busy), 0);
        repeat (4) tick();
        chk("abort_writes", acc_cnt - a0, 51);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_model_size", n, 19200);
        exp_addr_q.delete();
        exp_data_q.delete();
        run_rect(5, 5, 4, 3, 'hABC);

        // Synchronous reset in the middle of a stalled fill.
        wr_mode = 2;
        wait_ready();
        n = push_model(10, 20, 30, 4, 'h321);
        issue(10, 20, 30, 4, 'h321);
        tick();
        start = 1'b0;
        repeat (15) tick();
        chk("pre_reset_busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        chk("midrst_we", int'(we), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(ready), 1);
        chk("midrst_waddr", int'(waddr), 0);
        chk("midrst_wdata", int'(wdata), 0);
        chk("midrst_done", int'(done), 0);
        rst = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        tick();

        // Randomised rectangles, random write backpressure, many of them clipped or empty.
        for (int k = 0; k < 30; k++) begin
            wr_mode = int'($urandom_range(0, 2));
            run_rect(int'($urandom_range(0, 170)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 16)), int'($urandom_range(0, 16)),
                     int'($urandom_range(0, 4095)));
        end
        wr_mode = 0;
        run_rect(150, 115, 255, 127, 'hFFF);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule
